// File: rtl/midi_cmd_encoder.sv
// midi_cmd_encoder: turns a MIDI byte stream into 16-bit note-command words.
//
// Command word layout: bit15 = 1 start / 0 stop, [14:8] note, [7:0] velocity.
// 16'h7F00 (stop, note 127) means STOP_ALL downstream; 16'h0000 means no command.
// Commands are queued in a small FIFO and paced out one cycle each, with at
// least CMD_GAP all-zero cycles between consecutive words.
//
// Optional build macro MIDI_OMNI_EN: when defined, CHANNEL is ignored and
// channel messages on all 16 channels are accepted.
//
// Parameters:
//   CHANNEL    - MIDI channel (0-15) accepted
//   FIFO_DEPTH - command FIFO entries (power of 2, >= 2)
//   CMD_GAP    - minimum zero cycles on o_data between two command words
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   i_byte     - MIDI byte
//   i_valid    - i_byte valid this cycle (no backpressure)
//   o_data     - command word, 16'h0000 when idle
//   o_busy     - FIFO non-empty or gap counter running
//   o_overflow - sticky, a command was dropped because the FIFO was full
module midi_cmd_encoder #(
    parameter int unsigned CHANNEL    = 0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CMD_GAP    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    output logic [15:0] o_data,
    output logic        o_busy,
    output logic        o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (CMD_GAP < 1) ? 1 : $clog2(CMD_GAP + 1);

    typedef enum logic [1:0] {StIdle, StData1, StData2, StSkip} state_e;

    state_e      state_q, state_d;
    logic        rs_valid_q, rs_valid_d;
    logic [7:0]  rs_status_q, rs_status_d;
    logic [6:0]  d1_q, d1_d;

    logic [15:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [GW-1:0] gap_q;
    logic [15:0] data_q;
    logic        overflow_q;

    logic        is_sys, is_status, is_data;
    logic        eff_data1;
    logic [3:0]  msg_type;
    logic        cmd_valid;
    logic [15:0] cmd_word;
    logic        full, empty, pop, push, drop;

    function automatic logic chan_match(input logic [3:0] ch);
`ifdef MIDI_OMNI_EN
        return 1'b1 | (ch == 4'h0);
`else
        return ch == CHANNEL[3:0];
`endif
    endfunction

    // Byte classes; real-time bytes (F8-FF) fall in none of them and are ignored.
    assign is_sys    = (i_byte[7:3] == 5'b11110);
    assign is_status = i_byte[7] && (i_byte[7:4] != 4'hF);
    assign is_data   = !i_byte[7];
    assign msg_type  = rs_status_q[7:4];

    // A data byte in IDLE with a matching running status starts a new message.
    assign eff_data1 = (state_q == StData1) ||
                       ((state_q == StIdle) && rs_valid_q && chan_match(rs_status_q[3:0]));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rs_valid_q  <= 1'b0;
            rs_status_q <= 8'h00;
            d1_q        <= 7'h00;
        end else begin
            state_q     <= state_d;
            rs_valid_q  <= rs_valid_d;
            rs_status_q <= rs_status_d;
            d1_q        <= d1_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        rs_valid_d  = rs_valid_q;
        rs_status_d = rs_status_q;
        d1_d        = d1_q;
        if (i_valid) begin
            if (is_sys) begin
                rs_valid_d = 1'b0;
                state_d    = StIdle;
            end else if (is_status) begin
                rs_valid_d  = 1'b1;
                rs_status_d = i_byte;
                state_d     = chan_match(i_byte[3:0]) ? StData1 : StSkip;
            end else if (is_data) begin
                if (eff_data1) begin
                    d1_d = i_byte[6:0];
                    // Program change / channel pressure carry one data byte only.
                    state_d = ((msg_type == 4'hC) || (msg_type == 4'hD)) ? StData1 : StData2;
                end else if (state_q == StData2) begin
                    state_d = StData1;
                end
            end
        end
    end

    // Output logic: command word produced on the final data byte
    always_comb begin
        cmd_valid = 1'b0;
        cmd_word  = 16'h0000;
        if (i_valid && is_data && (state_q == StData2)) begin
            case (msg_type)
                4'h9: begin
                    if (i_byte[6:0] != 7'h00) begin
                        cmd_valid = 1'b1;
                        cmd_word  = {1'b1, d1_q, 1'b0, i_byte[6:0]};
                    end else begin
                        // Stop for note 0 would look like idle, so it is dropped.
                        cmd_valid = (d1_q != 7'h00);
                        cmd_word  = {1'b0, d1_q, 8'h00};
                    end
                end
                4'h8: begin
                    cmd_valid = (d1_q != 7'h00);
                    cmd_word  = {1'b0, d1_q, 8'h00};
                end
                4'hB: begin
                    // All-sound-off (120) and all-notes-off (123) map to STOP_ALL.
                    if ((d1_q == 7'd120) || (d1_q == 7'd123)) begin
                        cmd_valid = 1'b1;
                        cmd_word  = 16'h7F00;
                    end
                end
                default: ;
            endcase
        end
    end

    // FIFO control; a pop in the same cycle frees a slot for a push when full.
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && (gap_q == '0);
    assign push  = cmd_valid && (!full || pop);
    assign drop  = cmd_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_word;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            gap_q      <= '0;
            data_q     <= 16'h0000;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (pop) begin
                data_q <= mem_q[rd_ptr_q];
                gap_q  <= GW'(CMD_GAP);
            end else begin
                data_q <= 16'h0000;
                if (gap_q != '0) begin
                    gap_q <= gap_q - GW'(1);
                end
            end
        end
    end

    assign o_data     = data_q;
    assign o_busy     = !empty || (gap_q != '0);
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_midi_cmd_encoder.sv
module tb_midi_cmd_encoder;

    localparam int unsigned GAP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  i_byte;
    logic        i_valid;
    logic [15:0] o_data;
    logic        o_busy;
    logic        o_overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_edge = 0;
    int busy_fall = -1;
    logic busy_prev = 1'b0;
    logic [15:0] wq[$];
    int          tq[$];

    midi_cmd_encoder #(
        .CHANNEL(0),
        .FIFO_DEPTH(4),
        .CMD_GAP(GAP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_byte(i_byte),
        .i_valid(i_valid),
        .o_data(o_data),
        .o_busy(o_busy),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every non-zero output word with the edge count it appeared after.
    always @(negedge clk) begin
        if (o_data != 16'h0000) begin
            wq.push_back(o_data);
            tq.push_back(cyc);
        end
        if (busy_prev && !o_busy) busy_fall = cyc;
        busy_prev = o_busy;
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        i_byte    = b;
        i_valid   = 1'b1;
        last_edge = cyc + 1;
    endtask

    task automatic idle_in;
        @(negedge clk);
        i_valid = 1'b0;
        i_byte  = 8'h00;
    endtask

    task automatic clear_q;
        wq.delete();
        tq.delete();
    endtask

    task automatic settle;
        int n;
        idle_in();
        n = 0;
        while (o_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_busy) begin
            errors++;
            $display("FAIL settle_timeout o_busy=%0b required 0", o_busy);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_byte  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (o_data !== 16'h0000) begin
            errors++; $display("FAIL reset_o_data got=%h required 0000", o_data);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++; $display("FAIL reset_o_busy got=%b required 0", o_busy);
        end
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++; $display("FAIL reset_o_overflow got=%b required 0", o_overflow);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_note_on_off;
        logic [15:0] exp_w [3];
        exp_w[0] = 16'hC564;
        exp_w[1] = 16'h4500;
        exp_w[2] = 16'h4500;
        for (int s = 0; s < 3; s++) begin
            clear_q();
            if (s == 0) begin send(8'h90); send(8'h45); send(8'h64); end
            if (s == 1) begin send(8'h45); send(8'h00); end
            if (s == 2) begin send(8'h80); send(8'h45); send(8'h0F); end
            settle();
            checks++;
            if (wq.size() != 1) begin
                errors++; $display("FAIL note_count[%0d] got=%0d required 1", s, wq.size());
            end
            checks++;
            if (wq.size() < 1 || wq[0] !== exp_w[s]) begin
                errors++;
                $display("FAIL note_word[%0d] got=%h required %h", s,
                         (wq.size() > 0) ? wq[0] : 16'h0, exp_w[s]);
            end
            checks++;
            if (wq.size() < 1 || tq[0] != last_edge + 1) begin
                errors++;
                $display("FAIL note_latency[%0d] got=%0d required %0d", s,
                         (tq.size() > 0) ? tq[0] : -1, last_edge + 1);
            end
        end
    endtask

    task automatic test_realtime_abort;
        clear_q();
        send(8'h90); send(8'hF8); send(8'h28); send(8'hFE); send(8'h50);
        settle();
        checks++;
        if (wq.size() != 1 || wq[0] !== 16'hA850) begin
            errors++;
            $display("FAIL realtime_word count=%0d got=%h required 1 x A850", wq.size(),
                     (wq.size() > 0) ? wq[0] : 16'h0);
        end
        checks++;
        if (wq.size() < 1 || tq[0] != last_edge + 1) begin
            errors++;
            $display("FAIL realtime_latency got=%0d required %0d",
                     (tq.size() > 0) ? tq[0] : -1, last_edge + 1);
        end
        clear_q();
        send(8'h90); send(8'h3C); send(8'h80);
        settle();
        checks++;
        if (wq.size() != 0) begin
            errors++; $display("FAIL status_abort got=%0d words required 0", wq.size());
        end
    endtask

    task automatic test_channel_filter;
        int exp_n;
`ifdef MIDI_OMNI_EN
        exp_n = 1;
`else
        exp_n = 0;
`endif
        clear_q();
        send(8'h91); send(8'h45); send(8'h64);
        settle();
        checks++;
        if (wq.size() != exp_n || (exp_n == 1 && wq[0] !== 16'hC564)) begin
            errors++;
            $display("FAIL channel_filter count=%0d got=%h required %0d word(s) C564",
                     wq.size(), (wq.size() > 0) ? wq[0] : 16'h0, exp_n);
        end
        clear_q();
        send(8'hB0); send(8'h7B); send(8'h00);
        settle();
        checks++;
        if (wq.size() != 1 || wq[0] !== 16'h7F00) begin
            errors++;
            $display("FAIL all_notes_off count=%0d got=%h required 1 x 7F00", wq.size(),
                     (wq.size() > 0) ? wq[0] : 16'h0);
        end
        clear_q();
        send(8'hB0); send(8'h07); send(8'h40);
        send(8'hC0); send(8'h05); send(8'h06);
        settle();
        checks++;
        if (wq.size() != 0) begin
            errors++; $display("FAIL cc_pc_discard got=%0d words required 0", wq.size());
        end
    endtask

    task automatic test_pacing_overflow;
        int first_edge;
        logic [7:0] n;
        logic [7:0] v;
        logic [15:0] exp_w;
        clear_q();
        first_edge = 0;
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_pre got=%b required 0", o_overflow);
        end
        send(8'h90);
        for (int i = 0; i < 8; i++) begin
            send(8'h30 + 8'(i));
            if (i == 7) begin
                checks++;
                if (o_overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_early got=%b required 0", o_overflow);
                end
            end
            send(8'h40 + 8'(i));
            if (i == 0) first_edge = last_edge;
        end
        idle_in();
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_rise got=%b required 1", o_overflow);
        end
        settle();
        checks++;
        if (wq.size() != 7) begin
            errors++; $display("FAIL burst_count got=%0d required 7", wq.size());
        end
        for (int i = 0; i < 7; i++) begin
            n = 8'h30 + 8'(i);
            v = 8'h40 + 8'(i);
            exp_w = {1'b1, n[6:0], 1'b0, v[6:0]};
            checks++;
            if (i >= wq.size() || wq[i] !== exp_w || tq[i] != first_edge + 1 + i * (GAP + 1)) begin
                errors++;
                $display("FAIL burst_word[%0d] got=%h@%0d required %h@%0d", i,
                         (i < wq.size()) ? wq[i] : 16'h0, (i < tq.size()) ? tq[i] : -1,
                         exp_w, first_edge + 1 + i * (GAP + 1));
            end
        end
        checks++;
        if (wq.size() != 7 || busy_fall != tq[6] + GAP) begin
            errors++;
            $display("FAIL busy_fall got=%0d required %0d", busy_fall,
                     (tq.size() == 7) ? tq[6] + GAP : -1);
        end
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got=%b required 1", o_overflow);
        end
    endtask

    task automatic test_note0_sysex;
        clear_q();
        send(8'h80); send(8'h00); send(8'h00);
        settle();
        checks++;
        if (wq.size() != 0) begin
            errors++; $display("FAIL note0_stop got=%0d words required 0", wq.size());
        end
        clear_q();
        send(8'h90); send(8'hF0); send(8'h45); send(8'h64);
        settle();
        checks++;
        if (wq.size() != 0) begin
            errors++; $display("FAIL sysex_ignore got=%0d words required 0", wq.size());
        end
        clear_q();
        send(8'h90); send(8'h45); send(8'h64);
        settle();
        checks++;
        if (wq.size() != 1 || wq[0] !== 16'hC564) begin
            errors++;
            $display("FAIL sysex_recover count=%0d got=%h required 1 x C564", wq.size(),
                     (wq.size() > 0) ? wq[0] : 16'h0);
        end
    endtask

    task automatic test_reset_mid_message;
        clear_q();
        send(8'h90);
        send(8'h10); send(8'h11);
        send(8'h12); send(8'h13);
        send(8'h14); send(8'h15);
        send(8'h16);
        @(negedge clk);
        i_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset busy=%b ovf=%b required 1 1", o_busy, o_overflow);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (o_data !== 16'h0000 || o_busy !== 1'b0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset data=%h busy=%b ovf=%b required 0000 0 0",
                     o_data, o_busy, o_overflow);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_q();
        send(8'h45); send(8'h64);
        settle();
        checks++;
        if (wq.size() != 0) begin
            errors++; $display("FAIL post_reset_rs got=%0d words required 0", wq.size());
        end
        clear_q();
        send(8'h90); send(8'h45); send(8'h64);
        settle();
        checks++;
        if (wq.size() != 1 || wq[0] !== 16'hC564 || tq[0] != last_edge + 1) begin
            errors++;
            $display("FAIL post_reset_msg count=%0d got=%h@%0d required 1 x C564@%0d",
                     wq.size(), (wq.size() > 0) ? wq[0] : 16'h0,
                     (tq.size() > 0) ? tq[0] : -1, last_edge + 1);
        end
    endtask

    initial begin
        test_reset();
        test_note_on_off();
        test_realtime_abort();
        test_channel_filter();
        test_pacing_overflow();
        test_note0_sysex();
        test_reset_mid_message();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
